// File: rtl/arbitro_mux_3in.sv
// Round-robin arbiter that owns the select of a shared 3:1 datapath mux.
// Grants one requester at a time and releases on Fin, Req withdrawal or hold timeout.
module arbitro_mux_3in #(
  parameter int DB         = 32,
  parameter int MAX_CICLOS = 16,
  parameter int CW         = 5
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic [2:0] i_Req,
  input  logic [2:0] i_Fin,
  output logic [2:0] o_Gnt,
  output logic [1:0] o_Sel,
  output logic       o_Ocupado,
  output logic       o_Timeout
);

  typedef enum logic [1:0] {
    LIBRE     = 2'd0,
    CONCEDIDO = 2'd1,
    LIBERA    = 2'd2
  } estado_t;

  // A misconfigured instance never grants rather than producing a broken hold window.
  localparam logic CfgOk = (DB > 0) && (MAX_CICLOS >= 2) && ((2 ** CW) > MAX_CICLOS);
  localparam logic [CW-1:0] CntLast = CW'(MAX_CICLOS - 1);

  estado_t       r_state;
  logic [1:0]    r_ult;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_gnt;
  logic [1:0]    r_sel;
  logic          r_ocupado;
  logic          r_timeout;

  estado_t       w_stateNext;
  logic [1:0]    w_ultNext;
  logic [CW-1:0] w_cntNext;
  logic [2:0]    w_gntNext;
  logic [1:0]    w_selNext;
  logic          w_ocupadoNext;
  logic          w_timeoutNext;

  logic [1:0]    w_ord0, w_ord1, w_ord2;
  logic [1:0]    w_winner;
  logic          w_found;
  logic          w_reqK, w_finK;

  function automatic logic bitAt(input logic [2:0] vec, input logic [1:0] idx);
    case (idx)
      2'd0:    return vec[0];
      2'd1:    return vec[1];
      2'd2:    return vec[2];
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] oneHot(input logic [1:0] idx);
    case (idx)
      2'd0:    return 3'b001;
      2'd1:    return 3'b010;
      2'd2:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  // Search order starts just after the last granted requester and wraps mod 3.
  always_comb begin
    w_ord0 = 2'd0;
    w_ord1 = 2'd1;
    w_ord2 = 2'd2;
    case (r_ult)
      2'd0: begin w_ord0 = 2'd1; w_ord1 = 2'd2; w_ord2 = 2'd0; end
      2'd1: begin w_ord0 = 2'd2; w_ord1 = 2'd0; w_ord2 = 2'd1; end
      default: ;
    endcase

    w_found  = CfgOk;
    w_winner = w_ord0;
    if (bitAt(i_Req, w_ord0))      w_winner = w_ord0;
    else if (bitAt(i_Req, w_ord1)) w_winner = w_ord1;
    else if (bitAt(i_Req, w_ord2)) w_winner = w_ord2;
    else                           w_found  = 1'b0;

    w_reqK = bitAt(i_Req, r_ult);
    w_finK = bitAt(i_Fin, r_ult);
  end

  always_comb begin
    w_stateNext   = r_state;
    w_ultNext     = r_ult;
    w_cntNext     = r_cnt;
    w_gntNext     = r_gnt;
    w_selNext     = r_sel;
    w_ocupadoNext = r_ocupado;
    w_timeoutNext = 1'b0;

    case (r_state)
      LIBRE: begin
        w_gntNext     = 3'b000;
        w_ocupadoNext = 1'b0;
        if (w_found) begin
          w_stateNext   = CONCEDIDO;
          w_gntNext     = oneHot(w_winner);
          w_selNext     = w_winner;
          w_ultNext     = w_winner;
          w_cntNext     = '0;
          w_ocupadoNext = 1'b1;
        end
      end
      CONCEDIDO: begin
        // Fin outranks the hold limit, so a Fin on the last cycle is a normal release.
        if (w_finK || !w_reqK) begin
          w_stateNext   = LIBERA;
          w_gntNext     = 3'b000;
          w_ocupadoNext = 1'b0;
        end else if (r_cnt == CntLast) begin
          w_stateNext   = LIBERA;
          w_gntNext     = 3'b000;
          w_ocupadoNext = 1'b0;
          w_timeoutNext = 1'b1;
        end else begin
          w_cntNext = r_cnt + 1'b1;
        end
      end
      LIBERA: begin
        w_stateNext   = LIBRE;
        w_gntNext     = 3'b000;
        w_ocupadoNext = 1'b0;
      end
      default: begin
        w_stateNext   = LIBRE;
        w_gntNext     = 3'b000;
        w_ocupadoNext = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Reset) begin
      r_state   <= LIBRE;
      r_ult     <= 2'd2;
      r_cnt     <= '0;
      r_gnt     <= 3'b000;
      r_sel     <= 2'd0;
      r_ocupado <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_stateNext;
      r_ult     <= w_ultNext;
      r_cnt     <= w_cntNext;
      r_gnt     <= w_gntNext;
      r_sel     <= w_selNext;
      r_ocupado <= w_ocupadoNext;
      r_timeout <= w_timeoutNext;
    end
  end

  assign o_Gnt     = r_gnt;
  assign o_Sel     = r_sel;
  assign o_Ocupado = r_ocupado;
  assign o_Timeout = r_timeout;

endmodule

// File: tb/tb_arbitro_mux_3in.sv
// Self-checking bench for arbitro_mux_3in: directed scenarios then a long random run,
// every cycle compared against a transaction-level model of grant ownership.
module tb_arbitro_mux_3in;

  localparam int MAX = 16;

  logic       clk = 1'b0;
  logic       rstN;
  logic [2:0] req;
  logic [2:0] fin;
  logic [2:0] gnt;
  logic [1:0] sel;
  logic       ocupado;
  logic       timeoutO;

  int vectors     = 0;
  int miscompares = 0;

  // Model: who owns the path, how many cycles it has shown Gnt, and a pending idle gap.
  int         mOwner   = -1;
  int         mHeld    = 0;
  bit         mGap     = 1'b0;
  int         mLast    = 2;
  int         mSel     = 0;
  bit         mTimeout = 1'b0;

  always #5 clk = ~clk;

  arbitro_mux_3in #(.DB(32), .MAX_CICLOS(MAX), .CW(5)) dut (
    .i_Clk    (clk),
    .i_Reset  (rstN),
    .i_Req    (req),
    .i_Fin    (fin),
    .o_Gnt    (gnt),
    .o_Sel    (sel),
    .o_Ocupado(ocupado),
    .o_Timeout(timeoutO)
  );

  // Advance the model by one clock edge given the inputs seen at that edge.
  task automatic modelEdge(input logic r, input logic [2:0] rq, input logic [2:0] fn);
    if (!r) begin
      mOwner = -1; mHeld = 0; mGap = 1'b0; mLast = 2; mSel = 0; mTimeout = 1'b0;
    end else begin
      mTimeout = 1'b0;
      if (mOwner >= 0) begin
        if (fn[mOwner] || !rq[mOwner]) begin
          mOwner = -1; mGap = 1'b1;
        end else if (mHeld == MAX) begin
          mOwner = -1; mGap = 1'b1; mTimeout = 1'b1;
        end else begin
          mHeld++;
        end
      end else if (mGap) begin
        mGap = 1'b0;
      end else begin
        for (int d = 1; d <= 3; d++) begin
          int idx;
          idx = (mLast + d) % 3;
          if (mOwner < 0 && rq[idx]) begin
            mOwner = idx; mHeld = 1; mLast = idx; mSel = idx;
          end
        end
      end
    end
  endtask

  task automatic checkOutput(input string tag);
    logic [2:0] expGnt;
    expGnt = (mOwner >= 0) ? 3'(1 << mOwner) : 3'b000;
    vectors++;
    assert (gnt === expGnt) else begin
      miscompares++;
      $error("[TB] FAIL %s gnt got %b want %b", tag, gnt, expGnt);
    end
    vectors++;
    assert (sel === 2'(mSel)) else begin
      miscompares++;
      $error("[TB] FAIL %s sel got %0d want %0d", tag, sel, mSel);
    end
    vectors++;
    assert (ocupado === (mOwner >= 0)) else begin
      miscompares++;
      $error("[TB] FAIL %s ocupado got %b want %b", tag, ocupado, (mOwner >= 0));
    end
    vectors++;
    assert (timeoutO === mTimeout) else begin
      miscompares++;
      $error("[TB] FAIL %s timeout got %b want %b", tag, timeoutO, mTimeout);
    end
    vectors++;
    assert (sel !== 2'd3) else begin
      miscompares++;
      $error("[TB] FAIL %s sel_legal got %0d want 0..2", tag, sel);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [2:0] rq, input logic [2:0] fn,
                               input string tag);
    @(negedge clk);
    rstN = r; req = rq; fin = fn;
    @(posedge clk);
    #1;
    modelEdge(r, rq, fn);
    checkOutput(tag);
  endtask

  initial begin
    int         toCount;
    bit         seenTo;
    logic [2:0] rq;
    logic [2:0] fn;
    logic       r;

    rstN = 1'b0; req = 3'b000; fin = 3'b000;

    // Reset, then reset in the middle of a grant to B; A must win next.
    applyStimulus(1'b0, 3'b000, 3'b000, "reset");
    applyStimulus(1'b0, 3'b000, 3'b000, "reset");
    applyStimulus(1'b1, 3'b010, 3'b000, "grantB");
    applyStimulus(1'b1, 3'b010, 3'b000, "holdB");
    applyStimulus(1'b0, 3'b010, 3'b000, "resetMidGrant");
    applyStimulus(1'b1, 3'b111, 3'b000, "afterReset");
    applyStimulus(1'b1, 3'b000, 3'b000, "drop");
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 3'b000, 3'b000, "idle");

    // Single requester with Fin after three cycles.
    applyStimulus(1'b1, 3'b010, 3'b000, "single");
    for (int i = 0; i < 2; i++) applyStimulus(1'b1, 3'b010, 3'b000, "singleHold");
    applyStimulus(1'b1, 3'b010, 3'b010, "singleFin");
    applyStimulus(1'b1, 3'b000, 3'b000, "singleIdle");
    applyStimulus(1'b1, 3'b000, 3'b000, "singleIdle");

    // Round-robin with all requesting; pulse Fin for whoever holds the path.
    for (int i = 0; i < 16; i++) begin
      fn = (mOwner >= 0) ? 3'(1 << mOwner) : 3'b000;
      applyStimulus(1'b1, 3'b111, fn, "roundRobin");
    end
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 3'b000, 3'b000, "idle");

    // Hold timeout on C, then regrant to C after the turnaround.
    toCount = 0;
    seenTo  = 1'b0;
    for (int i = 0; i < 24; i++) begin
      applyStimulus(1'b1, 3'b100, 3'b000, "timeoutC");
      if (!seenTo) begin
        if (gnt == 3'b100) toCount++;
        if (timeoutO) seenTo = 1'b1;
      end
    end
    vectors++;
    assert (seenTo && toCount == MAX) else begin
      miscompares++;
      $error("[TB] FAIL timeoutLength got %0d cycles (seen=%0b) want %0d", toCount, seenTo, MAX);
    end
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 3'b000, 3'b000, "idle");

    // Foreign Fin ignored, then withdrawal releases A without a timeout.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 3'b001, 3'b000, "grantA");
    applyStimulus(1'b1, 3'b001, 3'b010, "foreignFin");
    applyStimulus(1'b1, 3'b001, 3'b110, "foreignFin");
    applyStimulus(1'b1, 3'b000, 3'b000, "withdraw");
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 3'b000, 3'b000, "idle");

    // Fin lands exactly on the last allowed cycle of the grant.
    for (int i = 0; i < 24; i++) begin
      fn = (mOwner == 0 && mHeld == MAX) ? 3'b001 : 3'b000;
      applyStimulus(1'b1, 3'b001, fn, "finLastCycle");
      if (fn != 3'b000) begin
        applyStimulus(1'b1, 3'b000, 3'b000, "finLastIdle");
        break;
      end
    end
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 3'b000, 3'b000, "idle");

    // Random run: sticky requests, sparse Fin, rare reset.
    rq = 3'b000;
    for (int i = 0; i < 10000; i++) begin
      for (int b = 0; b < 3; b++)
        if ($urandom_range(7) == 0) rq[b] = ~rq[b];
      for (int b = 0; b < 3; b++)
        fn[b] = ($urandom_range(5) == 0);
      r = ($urandom_range(999) != 0);
      applyStimulus(r, rq, fn, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
